uart_rx: RTL

- Receive-side counterpart of the team's UART transmitter: recovers 8-bit frames from the serial line using an oversampling clock.
- Frame: start (0), 8 data bits LSB first, optional parity, one stop (1).
- Runtime-configurable prescale, parity enable and parity type, matching the transmitter's controls.
- Delivers P_DATA with a one-cycle valid pulse plus per-frame parity and stop error flags to the host-side logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sampler.sv | 61 ++++++
 rtl/uart_rx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants
// for the UART transmitter and receiver.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, per-bit
// edge counter and 3-point majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  rx,
  output logic                  sampled_bit,
  output logic                  bit_done
);

  localparam logic [PRESCALE_W-1:0] ONE = 1;

  logic [1:0]            sync_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic [2:0]            smp_q;

  assign half = prescale >> 1;
  assign last = prescale - ONE;
  assign rx   = sync_q[1];

  // two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_in};
  end

  // edge counter wraps every bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt_q <= '0;
    else if (!run)         cnt_q <= '0;
    else if (cnt_q == last) cnt_q <= '0;
    else                   cnt_q <= cnt_q + ONE;
  end

  // capture three samples around mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
    end else if (run) begin
      if (cnt_q == half - ONE) smp_q[0] <= rx;
      if (cnt_q == half)       smp_q[1] <= rx;
      if (cnt_q == half + ONE) smp_q[2] <= rx;
    end
  end

  assign sampled_bit = (smp_q[0] & smp_q[1]) |
                       (smp_q[0] & smp_q[2]) |
                       (smp_q[1] & smp_q[2]);

  assign bit_done = run && (cnt_q == last);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: frame FSM, shift register and
// parity/stop checking for the UART receiver.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  state_t                state_q;
  state_t                state_d;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_W-1:0]     shift_q;
  logic [CW-1:0]         bit_cnt_q;
  logic                  par_bad_q;
  logic                  rx;
  logic                  sampled_bit;
  logic                  bit_done;
  logic                  run;
  logic                  start_det;
  logic                  frame_end;
  logic                  par_fail;

  assign run       = (state_q != IDLE);
  assign busy      = run;
  assign start_det = (state_q == IDLE) && !rx;
  assign frame_end = (state_q == STOP) && bit_done;
  assign par_fail  = par_bad_q & par_en_q;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_in       (RX_IN),
    .run         (run),
    .prescale    (presc_q),
    .rx          (rx),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done)
  );

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!rx) state_d = START;
      end
      START: begin
        if (bit_done)
          state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && bit_cnt_q == LAST_BIT)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // latch line config at the start edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (start_det) begin
      presc_q   <= PRESCALE;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  // data bit counter and LSB-first shifter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q != DATA) begin
      bit_cnt_q <= '0;
    end else if (bit_done) begin
      bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_ONE;
      if (DATA_W > 1)
        shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
      else
        shift_q <= sampled_bit;
    end
  end

  // parity mismatch flag for this frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      par_bad_q <= 1'b0;
    else if (state_q == START)
      par_bad_q <= 1'b0;
    else if (state_q == PARITY && bit_done)
      par_bad_q <= sampled_bit ^ (^shift_q) ^ par_typ_q;
  end

  // end-of-frame result pulses and data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (frame_end) begin
        STP_ERR <= !sampled_bit;
        PAR_ERR <= par_fail;
        if (sampled_bit && !par_fail) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shift_q;
        end
      end
    end
  end

endmodule
